// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle for uart_cmd_ctrl: rx FIFO read side, tx FIFO write side,
// register bus and the busy flag. master = controller, slave = surrounding logic.
interface uart_cmd_ctrl_if #(
    parameter int unsigned FIFO_WIDTH = 8
);
    logic [FIFO_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [FIFO_WIDTH-1:0] tx_wr_data;
    logic                  tx_wr;
    logic                  tx_full;
    logic [7:0]            reg_addr;
    logic [7:0]            reg_wdata;
    logic                  reg_wr;
    logic                  reg_rd;
    logic [7:0]            reg_rdata;
    logic                  busy;

    modport master (
        input  rx_data, rx_valid, tx_full, reg_rdata,
        output rx_ready, tx_wr_data, tx_wr, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_full, reg_rdata,
        input  rx_ready, tx_wr_data, tx_wr, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses A5/CMD/ADDR/[DATA]/CHK request frames from the
// rx FIFO, performs one register write or read, and answers 5A/STATUS/[DATA]
// into the tx FIFO. Optional inter-byte timeout enabled by UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
    parameter int unsigned FIFO_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_ctrl_if.master bus
);

    localparam logic [7:0] SofReq  = 8'hA5;
    localparam logic [7:0] SofRsp  = 8'h5A;
    localparam logic [7:0] StatAck = 8'h06;
    localparam logic [7:0] StatNak = 8'h15;
    localparam logic [7:0] CmdWr   = 8'h01;
    localparam logic [7:0] CmdRd   = 8'h02;

    // Only byte-wide FIFOs and a non-zero timeout are meaningful.
    if (FIFO_WIDTH != 8 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("uart_cmd_ctrl: unsupported FIFO_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [3:0] {
        StIdle,
        StGetCmd,
        StGetAddr,
        StGetData,
        StGetChk,
        StExec,
        StRdWait,
        StRspSof,
        StRspStat,
        StRspData
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q, ack_d;
    logic       rx_ready_q, rx_ready_d;

    logic [7:0] rx_byte;
    logic       accept;
    logic       in_get;
    logic [7:0] chk_exp;
    logic       tx_wr;
    logic [7:0] tx_byte;
    logic       reg_wr;
    logic       reg_rd;

    assign rx_byte = bus.rx_data[7:0];
    assign accept  = rx_ready_q && bus.rx_valid;
    assign in_get  = (state_q == StGetCmd) || (state_q == StGetAddr) ||
                     (state_q == StGetData) || (state_q == StGetChk);
    // Data only contributes to the checksum for write frames.
    assign chk_exp = cmd_q ^ addr_q ^ ((cmd_q == CmdWr) ? data_q : 8'h00);

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] to_cnt_q, to_cnt_d;
    logic            to_hit;

    // Counts idle cycles while collecting a frame; any accepted byte restarts it.
    always_comb begin
        to_cnt_d = '0;
        to_hit   = 1'b0;
        if (in_get && !accept) begin
            if (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                to_hit = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // Next-state and output decode for the frame parser and responder.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        tx_wr   = 1'b0;
        tx_byte = 8'h00;
        reg_wr  = 1'b0;
        reg_rd  = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept && rx_byte == SofReq) begin
                    state_d = StGetCmd;
                end
            end
            StGetCmd: begin
                if (accept) begin
                    cmd_d   = rx_byte;
                    state_d = StGetAddr;
                end
            end
            StGetAddr: begin
                if (accept) begin
                    addr_d  = rx_byte;
                    state_d = (cmd_q == CmdWr) ? StGetData : StGetChk;
                end
            end
            StGetData: begin
                if (accept) begin
                    data_d  = rx_byte;
                    state_d = StGetChk;
                end
            end
            StGetChk: begin
                if (accept) begin
                    // Unknown commands are NAKed just like bad checksums.
                    ack_d   = (rx_byte == chk_exp) && (cmd_q == CmdWr || cmd_q == CmdRd);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (ack_q && cmd_q == CmdWr) begin
                    reg_wr  = 1'b1;
                    state_d = StRspSof;
                end else if (ack_q && cmd_q == CmdRd) begin
                    reg_rd  = 1'b1;
                    state_d = StRdWait;
                end else begin
                    state_d = StRspSof;
                end
            end
            StRdWait: begin
                rdata_d = bus.reg_rdata;
                state_d = StRspSof;
            end
            StRspSof: begin
                if (!bus.tx_full) begin
                    tx_wr   = 1'b1;
                    tx_byte = SofRsp;
                    state_d = StRspStat;
                end
            end
            StRspStat: begin
                if (!bus.tx_full) begin
                    tx_wr   = 1'b1;
                    tx_byte = ack_q ? StatAck : StatNak;
                    state_d = (ack_q && cmd_q == CmdRd) ? StRspData : StIdle;
                end
            end
            StRspData: begin
                if (!bus.tx_full) begin
                    tx_wr   = 1'b1;
                    tx_byte = rdata_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        if (to_hit) begin
            state_d = StIdle;
        end
`endif

        rx_ready_d = (state_d == StIdle) || (state_d == StGetCmd) || (state_d == StGetAddr) ||
                     (state_d == StGetData) || (state_d == StGetChk);
    end

    // State and frame field registers; rx_ready is registered so it stays low in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cmd_q      <= 8'h00;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            rdata_q    <= 8'h00;
            ack_q      <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.tx_wr      = tx_wr;
    assign bus.tx_wr_data = FIFO_WIDTH'(tx_byte);
    assign bus.reg_addr   = addr_q;
    assign bus.reg_wdata  = data_q;
    assign bus.reg_wr     = reg_wr;
    assign bus.reg_rd     = reg_rd;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized bench for uart_cmd_ctrl with a frame-level reference model.
module tb_uart_cmd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.FIFO_WIDTH(8)) bus ();

    uart_cmd_ctrl #(
        .FIFO_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } reg_op_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] rxq[$];
    logic [7:0] exp_tx[$];
    reg_op_t    exp_op[$];
    logic [7:0] mem[256];

    logic       rx_fire    = 1'b0;
    logic       rd_pend    = 1'b0;
    logic [7:0] rd_addr    = 8'h00;
    logic       force_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Frame-level reference: what a request must produce, straight from the protocol rules.
    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                               input logic [7:0] data, input logic [7:0] chkb,
                               output logic [7:0] rsp[3], output int n, output int op);
        logic [7:0] x;
        logic       good;
        x    = (cmd == 8'h01) ? (cmd ^ addr ^ data) : (cmd ^ addr);
        good = (x == chkb) && (cmd == 8'h01 || cmd == 8'h02);
        rsp[0] = 8'h5A;
        rsp[1] = good ? 8'h06 : 8'h15;
        rsp[2] = mem[addr];
        n  = (good && cmd == 8'h02) ? 3 : 2;
        op = !good ? 0 : (cmd == 8'h01) ? 1 : 2;
    endtask

    // Queue a frame's bytes (skipping the first 'pre' already sent) and its expectations.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] data, input logic [7:0] chkb, input int pre);
        logic [7:0] rsp[3];
        logic [7:0] fr[$];
        int         n;
        int         op;
        model_frame(cmd, addr, data, chkb, rsp, n, op);
        fr.push_back(8'hA5);
        fr.push_back(cmd);
        fr.push_back(addr);
        if (cmd == 8'h01) fr.push_back(data);
        fr.push_back(chkb);
        for (int i = pre; i < fr.size(); i++) rxq.push_back(fr[i]);
        for (int i = 0; i < n; i++) exp_tx.push_back(rsp[i]);
        if (op != 0) exp_op.push_back('{is_wr: (op == 1), addr: addr, data: data});
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (rxq.size() == 0 && exp_tx.size() == 0 && exp_op.size() == 0 && !bus.busy) break;
        end
        chk(name, (k < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_rx_empty(input string name);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (rxq.size() == 0) break;
        end
        chk(name, (k < 500) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Environment: rx FIFO front, registered read data, tx FIFO backpressure.
    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_full   = 1'b0;
        bus.reg_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rx_fire && rxq.size() > 0) void'(rxq.pop_front());
            rx_fire      = 1'b0;
            bus.rx_valid = (rxq.size() > 0);
            bus.rx_data  = bus.rx_valid ? rxq[0] : 8'($urandom);
            // Read data is valid only in the cycle right after reg_rd.
            bus.reg_rdata = rd_pend ? mem[rd_addr] : 8'($urandom);
            rd_pend       = 1'b0;
            bus.tx_full   = force_full || ($urandom_range(0, 3) == 0);
        end
    end

    // Compare process: checks every strobe against the model queues.
    initial begin
        reg_op_t op;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_ctrl", {27'd0, bus.rx_ready, bus.tx_wr, bus.reg_wr, bus.reg_rd,
                                   bus.busy}, 32'd0);
                chk("reset_data", {8'd0, bus.tx_wr_data, bus.reg_addr, bus.reg_wdata}, 32'd0);
                rx_fire = 1'b0;
                rd_pend = 1'b0;
            end else begin
                rx_fire = bus.rx_valid && bus.rx_ready;
                if (bus.tx_wr) begin
                    chk("tx_while_full", {31'd0, bus.tx_full}, 32'd0);
                    if (exp_tx.size() == 0) begin
                        chk("tx_unexpected", {24'd0, bus.tx_wr_data}, 32'hFFFF_FFFF);
                    end else begin
                        chk("tx_byte", {24'd0, bus.tx_wr_data}, {24'd0, exp_tx.pop_front()});
                    end
                end
                if (bus.reg_wr || bus.reg_rd) begin
                    chk("reg_exclusive", {31'd0, bus.reg_wr && bus.reg_rd}, 32'd0);
                    if (exp_op.size() == 0) begin
                        chk("reg_unexpected", {24'd0, bus.reg_addr}, 32'hFFFF_FFFF);
                    end else begin
                        op = exp_op.pop_front();
                        chk("reg_kind", {31'd0, bus.reg_wr}, {31'd0, op.is_wr});
                        chk("reg_addr", {24'd0, bus.reg_addr}, {24'd0, op.addr});
                        if (op.is_wr) chk("reg_wdata", {24'd0, bus.reg_wdata}, {24'd0, op.data});
                    end
                    if (bus.reg_rd) begin
                        rd_pend = 1'b1;
                        rd_addr = bus.reg_addr;
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [7:0] rsp[3];
        int         n;
        int         op;
        logic [7:0] cmd, addr, data, good, chkb, b;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h20] = 8'h77;

        // Pin the model with hand-computed frames.
        model_frame(8'h01, 8'h10, 8'h3C, 8'h2D, rsp, n, op);
        chk("pin_wr", {rsp[0], rsp[1], 8'(n), 8'(op)}, 32'h5A06_0201);
        model_frame(8'h02, 8'h20, 8'h00, 8'h22, rsp, n, op);
        chk("pin_rd", {rsp[0], rsp[1], rsp[2], 4'(n), 4'(op)}, 32'h5A06_7732);
        model_frame(8'h01, 8'h10, 8'h3C, 8'h00, rsp, n, op);
        chk("pin_badchk", {rsp[0], rsp[1], 8'(n), 8'(op)}, 32'h5A15_0200);
        model_frame(8'h07, 8'h10, 8'h00, 8'h17, rsp, n, op);
        chk("pin_badcmd", {rsp[0], rsp[1], 8'(n), 8'(op)}, 32'h5A15_0200);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Directed frames: write, read, junk plus bad checksum.
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 0);
        wait_drain("drain_wr");
        send_frame(8'h02, 8'h20, 8'h00, 8'h22, 0);
        wait_drain("drain_rd");
        rxq.push_back(8'h00);
        rxq.push_back(8'h11);
        send_frame(8'h01, 8'h10, 8'h3C, 8'h00, 0);
        wait_drain("drain_bad");

        // Response stalled by a full tx FIFO.
        force_full = 1'b1;
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 0);
        repeat (28) @(negedge clk);
        chk("full_hold", {24'd0, 8'(exp_tx.size())}, 32'd2);
        force_full = 1'b0;
        wait_drain("drain_full");

        // Reset after the ADDR byte of a read.
        rxq.push_back(8'hA5);
        rxq.push_back(8'h02);
        rxq.push_back(8'h20);
        wait_rx_empty("rst_rx_empty");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", {30'd0, bus.busy, bus.rx_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdy_before_edge", {31'd0, bus.rx_ready}, 32'd0);
        @(negedge clk);
        chk("rdy_after_edge", {31'd0, bus.rx_ready}, 32'd1);
        send_frame(8'h02, 8'h20, 8'h00, 8'h22, 0);
        wait_drain("drain_post_rst");

`ifdef UART_CMD_TIMEOUT_EN
        // Partial frame must be abandoned after 16 idle cycles.
        rxq.push_back(8'hA5);
        rxq.push_back(8'h01);
        wait_rx_empty("to_rx_empty");
        repeat (20) @(negedge clk);
        chk("timeout_idle", {31'd0, bus.busy}, 32'd0);
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 0);
        wait_drain("drain_timeout");
`else
        // Without the timeout a partial frame waits indefinitely.
        rxq.push_back(8'hA5);
        rxq.push_back(8'h01);
        wait_rx_empty("wait_rx_empty");
        repeat (40) @(negedge clk);
        chk("no_timeout_busy", {31'd0, bus.busy}, 32'd1);
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 2);
        wait_drain("drain_no_timeout");
`endif

        // Random frames with junk, bad checksums, odd commands and back-to-back arrival.
        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                rxq.push_back(b);
            end
            n    = $urandom_range(0, 99);
            cmd  = (n < 50) ? 8'h01 : (n < 85) ? 8'h02 : 8'($urandom);
            addr = 8'($urandom);
            data = 8'($urandom);
            good = (cmd == 8'h01) ? (cmd ^ addr ^ data) : (cmd ^ addr);
            chkb = ($urandom_range(0, 4) == 0) ? (good ^ 8'($urandom_range(1, 255))) : good;
            send_frame(cmd, addr, data, chkb, 0);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_drain("drain_random");

        chk("tx_left", {24'd0, 8'(exp_tx.size())}, 32'd0);
        chk("op_left", {24'd0, 8'(exp_op.size())}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, byte width of rx/tx data (only 8 supported).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, inter-byte timeout in clk cycles.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  FIFO_WIDTH  received byte from rx FIFO.
REQ-006 SHALL have port rx_valid  input  1  rx_data holds a byte.
REQ-007 SHALL have port rx_ready  output  1  byte consumed when rx_valid && rx_ready.
REQ-008 SHALL have port tx_wr_data  output  FIFO_WIDTH  response byte to tx FIFO.
REQ-009 SHALL have port tx_wr  output  1  one-cycle write strobe to tx FIFO.
REQ-010 SHALL have port tx_full  input  1  tx FIFO full; no tx_wr while high.
REQ-011 SHALL have port reg_addr  output  8  register address.
REQ-012 SHALL have port reg_wdata  output  8  register write data.
REQ-013 SHALL have port reg_wr  output  1  one-cycle register write strobe.
REQ-014 SHALL have port reg_rd  output  1  one-cycle register read strobe.
REQ-015 SHALL have port reg_rdata  input  8  read data, valid exactly 1 cycle after reg_rd.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL parse request frames: 0xA5, CMD, ADDR, [DATA if CMD=0x01], CHK; CHK = XOR of CMD, ADDR and DATA (if present).
REQ-018 SHALL use states IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, RSP_SOF, RSP_STAT, RSP_DATA.
REQ-019 SHALL drive rx_ready high only in IDLE and GET_* states; one byte accepted per cycle maximum.
REQ-020 In IDLE, SHALL discard any byte other than 0xA5 and remain in IDLE.
REQ-021 CMD 0x01 (write) SHALL go GET_ADDR->GET_DATA->GET_CHK; CMD 0x02 (read) SHALL go GET_ADDR->GET_CHK.
REQ-022 Any other CMD value SHALL still collect ADDR and CHK, then respond NAK without register access.
REQ-023 On CHK mismatch, SHALL skip register access and respond NAK (0x15).
REQ-024 EXEC for valid write SHALL pulse reg_wr one cycle with reg_addr/reg_wdata stable that cycle, then go RSP_SOF.
REQ-025 EXEC for valid read SHALL pulse reg_rd one cycle, go RD_WAIT, capture reg_rdata next cycle, then go RSP_SOF.
REQ-026 Response SHALL be 0x5A, STATUS (0x06 ACK / 0x15 NAK), then captured read data only for ACKed reads.
REQ-027 Each RSP_* state SHALL assert tx_wr for exactly one cycle when tx_full is low and hold (no strobe) while tx_full is high.
REQ-028 After last response byte, SHALL return to IDLE; next 0xA5 accepted the following cycle.
REQ-029 Bytes arriving during EXEC/RD_WAIT/RSP_* SHALL remain in the rx FIFO (rx_ready low), not be dropped.
REQ-030 reg_wr and reg_rd SHALL never be asserted in the same cycle.

Reset
REQ-031 On rst high, SHALL asynchronously enter IDLE with rx_ready=0, tx_wr=0, tx_wr_data=0, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0, timeout counter=0.
REQ-032 rx_ready SHALL rise on the first clk edge after rst deasserts.
REQ-033 Reset mid-frame or mid-response SHALL abandon the frame with no further tx_wr or reg strobe.

Configuration
REQ-034 With macro UART_CMD_TIMEOUT_EN defined, a counter SHALL run in GET_* states, clear on each accepted byte, and on reaching TIMEOUT_CYCLES return to IDLE with no response.
REQ-035 Without UART_CMD_TIMEOUT_EN, no timeout logic SHALL exist and GET_* states SHALL wait indefinitely.

Verification
REQ-036 Write A5 01 10 3C 2D -> reg_wr one cycle with reg_addr=0x10, reg_wdata=0x3C; tx bytes 5A 06.
REQ-037 Read A5 02 20 22, reg_rdata=0x77 -> reg_rd one cycle at reg_addr=0x20; tx bytes 5A 06 77.
REQ-038 Write A5 01 10 3C 00 (bad CHK) -> no reg_wr; tx bytes 5A 15; bytes 00 11 before A5 ignored.
REQ-039 tx_full held high 20 cycles during response -> no tx_wr while full; 5A 06 delivered unchanged and in order afterwards.
REQ-040 With UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: send A5 01 then idle 16 cycles -> IDLE, no response; next full frame ACKed.
REQ-041 Assert rst after ADDR byte of a read -> IDLE immediately, no reg_rd, no tx_wr; subsequent frame processed normally.
